// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, counter widths and bit-period helper.
package uart_pkg;

   localparam int unsigned CNT_W  = 16;
   localparam int unsigned BCNT_W = 4;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   // Clocks per bit for a clock given in MHz and a line rate in bit/s
   function automatic int unsigned calc_cycle(input int unsigned clk_mhz,
                                              input int unsigned baud);
      return (clk_mhz * 32'd1000000) / baud;
   endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: ticks on the last clock of each CYCLE-long bit period.
module uart_baud_gen
   import uart_pkg::*;
#(
   parameter int unsigned CYCLE = 10
) (
   input  logic i_clk_sys,
   input  logic i_rst,
   input  logic i_en,
   input  logic i_clr,
   output logic o_tick
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(CYCLE - 1);

   logic [CNT_W-1:0] cnt_q;

   assign o_tick = i_en && (cnt_q == LAST);

   // Counter with synchronous clear, wraps to zero after the last clock of a period
   always_ff @(posedge i_clk_sys or posedge i_rst) begin
      if (i_rst) begin
         cnt_q <= '0;
      end else if (i_clr) begin
         cnt_q <= '0;
      end else if (i_en) begin
         if (cnt_q == LAST) begin
            cnt_q <= '0;
         end else begin
            cnt_q <= cnt_q + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: valid/ready word in, start + LSB-first data + optional parity + stop bits out.
module uart_tx
   import uart_pkg::*;
#(
   parameter int unsigned CLK_FRE     = 50,
   parameter int unsigned DATA_WIDTH  = 8,
   parameter int unsigned PARITY_ON   = 0,
   parameter int unsigned PARITY_TYPE = 0,
   parameter int unsigned BAUD_RATE   = 9600,
   parameter int unsigned STOP_BITS   = 1
) (
   input  logic                  i_clk_sys,
   input  logic                  i_rst,
   input  logic [DATA_WIDTH-1:0] i_tx_data,
   input  logic                  i_tx_valid,
   output logic                  o_tx_ready,
   output logic                  o_uart_tx,
   output logic                  o_tx_busy,
   output logic                  o_tx_done
);

   localparam int unsigned CYCLE = calc_cycle(CLK_FRE, BAUD_RATE);

   // Reject parameter sets the datapath cannot represent
   if (CYCLE < 2) begin : g_bad_cycle
      $error("uart_tx: CLK_FRE/BAUD_RATE gives fewer than 2 clocks per bit");
   end
   if (DATA_WIDTH < 5 || DATA_WIDTH > 9) begin : g_bad_width
      $error("uart_tx: DATA_WIDTH must be 5..9");
   end
   if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
      $error("uart_tx: STOP_BITS must be 1 or 2");
   end

   state_t                state_q,  state_n;
   logic [DATA_WIDTH-1:0] shift_q,  shift_n;
   logic [BCNT_W-1:0]     bit_cnt_q, bit_cnt_n;
   logic                  parity_q, parity_n;
   logic                  tx_q,     tx_n;
   logic                  ready_q,  ready_n;
   logic                  busy_q,   busy_n;
   logic                  done_q,   done_n;
   logic                  accept;
   logic                  tick;

   assign accept = i_tx_valid && ready_q;

   uart_baud_gen #(
      .CYCLE (CYCLE)
   ) u_baud_gen (
      .i_clk_sys (i_clk_sys),
      .i_rst     (i_rst),
      .i_en      (busy_q),
      .i_clr     (accept),
      .o_tick    (tick)
   );

   // Next-state and next-output logic; the line value for each bit is decided one edge ahead
   always_comb begin
      state_n   = state_q;
      shift_n   = shift_q;
      bit_cnt_n = bit_cnt_q;
      parity_n  = parity_q;
      tx_n      = tx_q;
      ready_n   = ready_q;
      busy_n    = busy_q;
      done_n    = 1'b0;

      case (state_q)
         IDLE: begin
            tx_n = 1'b1;
            if (accept) begin
               state_n   = START;
               shift_n   = i_tx_data;
               parity_n  = (^i_tx_data) ^ 1'(PARITY_TYPE);
               bit_cnt_n = '0;
               tx_n      = 1'b0;
               ready_n   = 1'b0;
               busy_n    = 1'b1;
            end
         end
         START: begin
            if (tick) begin
               state_n   = DATA;
               tx_n      = shift_q[0];
               shift_n   = shift_q >> 1;
               bit_cnt_n = '0;
            end
         end
         DATA: begin
            if (tick) begin
               if (bit_cnt_q == BCNT_W'(DATA_WIDTH - 1)) begin
                  bit_cnt_n = '0;
                  if (PARITY_ON != 0) begin
                     state_n = PARITY;
                     tx_n    = parity_q;
                  end else begin
                     state_n = STOP;
                     tx_n    = 1'b1;
                  end
               end else begin
                  bit_cnt_n = bit_cnt_q + BCNT_W'(1);
                  tx_n      = shift_q[0];
                  shift_n   = shift_q >> 1;
               end
            end
         end
         PARITY: begin
            if (tick) begin
               state_n   = STOP;
               tx_n      = 1'b1;
               bit_cnt_n = '0;
            end
         end
         STOP: begin
            tx_n = 1'b1;
            if (tick) begin
               if (bit_cnt_q == BCNT_W'(STOP_BITS - 1)) begin
                  state_n   = IDLE;
                  bit_cnt_n = '0;
                  ready_n   = 1'b1;
                  busy_n    = 1'b0;
                  done_n    = 1'b1;
               end else begin
                  bit_cnt_n = bit_cnt_q + BCNT_W'(1);
               end
            end
         end
         default: begin
            state_n = IDLE;
            tx_n    = 1'b1;
            ready_n = 1'b1;
            busy_n  = 1'b0;
         end
      endcase
   end

   // State, datapath and output registers; reset leaves the line idle high
   always_ff @(posedge i_clk_sys or posedge i_rst) begin
      if (i_rst) begin
         state_q   <= IDLE;
         shift_q   <= '0;
         bit_cnt_q <= '0;
         parity_q  <= 1'b0;
         tx_q      <= 1'b1;
         ready_q   <= 1'b1;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_n;
         shift_q   <= shift_n;
         bit_cnt_q <= bit_cnt_n;
         parity_q  <= parity_n;
         tx_q      <= tx_n;
         ready_q   <= ready_n;
         busy_q    <= busy_n;
         done_q    <= done_n;
      end
   end

   assign o_uart_tx  = tx_q;
   assign o_tx_ready = ready_q;
   assign o_tx_busy  = busy_q;
   assign o_tx_done  = done_q;

endmodule
